// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one multiplier bit per clock over a
// shared add/subtract/shift datapath, valid/ready on both operand and product sides.
module booth_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH-1:0] q_sh;
    logic             accept;
    logic             last_step;

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (cnt == LAST);

    // Booth recode of {Q[0],q_1}, then arithmetic shift of {A,Q,q_1}.
    // A carries one guard bit so -2^(W-1) * -2^(W-1) cannot overflow.
    always_comb begin
        sum = acc;
        case ({q_reg[0], q_1})
            2'b10:   sum = acc - m_reg;
            2'b01:   sum = acc + m_reg;
            default: sum = acc;
        endcase
        acc_sh = {sum[WIDTH], sum[WIDTH:1]};
        q_sh   = {sum[0], q_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)             state_nxt = RUN;
            RUN:     if (last_step)            state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg     <= '0;
            acc       <= '0;
            q_reg     <= '0;
            q_1       <= 1'b0;
            cnt       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_reg <= {a[WIDTH-1], a};
                        q_reg <= b;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_sh;
                    q_reg <= q_sh;
                    q_1   <= q_reg[0];
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        y         <= {acc_sh[WIDTH-1:0], q_sh};
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // y is deliberately kept after the handshake
                    if (out_valid && out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed + exhaustive bench for booth_seq_ctrl (WIDTH=4) with an expected-product queue.
module tb_booth_seq_ctrl;

    localparam int W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] a = '0;
    logic signed [W-1:0] b = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [2*W-1:0]      y;
    logic                busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_cyc;
    logic [2*W-1:0] exp_q[$];

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] x,
                                               input logic signed [W-1:0] z);
        logic signed [2*W-1:0] p;
        p = x * z;
        return p;
    endfunction

    task automatic send(input logic signed [W-1:0] x, input logic signed [W-1:0] z);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        a = x;
        b = z;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom_range(15, 0);
        b = $urandom_range(15, 0);
        acc_cyc = cyc;
        exp_q.push_back(ref_mul(x, z));
    endtask

    task automatic receive(input int hold, input bit chk_busy);
        int n = 0;
        logic [2*W-1:0] yv;
        logic [2*W-1:0] e;
        while (!out_valid && n < 20) begin
            if (chk_busy) begin
                check("busy_run", {31'd0, busy}, 32'd1);
                check("in_ready_run", {31'd0, in_ready}, 32'd0);
            end
            tick();
            n++;
        end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        check("latency", cyc - acc_cyc, W);
        yv = y;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("y", {24'd0, yv}, {24'd0, e});
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_y", {24'd0, y}, {24'd0, yv});
            if (chk_busy) check("in_ready_done", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("y_retained", {24'd0, y}, {24'd0, yv});
    endtask

    initial begin
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // basic with busy/in_ready tracking
        send(4'sd3, -4'sd2);
        receive(0, 1'b1);
        check("basic_val", {24'd0, y}, 32'h000000FA);

        // corners
        send(-4'sd8, -4'sd8); receive(0, 1'b0);
        check("neg8neg8", {24'd0, y}, 32'h40);
        send(-4'sd8, 4'sd7);  receive(1, 1'b0);
        check("neg8pos7", {24'd0, y}, 32'hC8);
        send(4'sd7, 4'sd7);   receive(0, 1'b0);
        check("pos7pos7", {24'd0, y}, 32'h31);
        send(4'sd0, -4'sd8);  receive(0, 1'b0);
        check("zero", {24'd0, y}, 32'h00);

        // backpressure
        send(-4'sd3, 4'sd5);
        receive(10, 1'b1);

        // in_valid during RUN is ignored
        send(4'sd2, 4'sd3);
        a = 4'sd5;
        b = 4'sd5;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        receive(2, 1'b1);
        check("ignore_val", {24'd0, y}, 32'h06);
        for (int i = 0; i < 8; i++) tick();
        check("no_second_result", {31'd0, out_valid}, 32'd0);
        check("no_second_busy", {31'd0, busy}, 32'd0);

        // async reset mid-RUN
        send(4'sd7, 4'sd7);
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_y", {24'd0, y}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        void'(exp_q.pop_front());
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_y", {24'd0, y}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(-4'sd1, -4'sd1);
        receive(0, 1'b1);
        check("neg1neg1", {24'd0, y}, 32'h01);

        // exhaustive, random backpressure
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                send(4'(i), 4'(j));
                receive($urandom_range(3, 0), 1'b0);
            end
        end
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Multi-cycle radix-2 Booth multiplier with a controller FSM. It processes one multiplier bit per clock over a shared add/subtract/shift datapath.
- Operands are accepted through a valid/ready input handshake. The product is returned through a valid/ready output handshake.
- It replaces the combinational Booth multiplier where area matters more than latency. It handles the most-negative operand correctly without special-case correction.

Parameters:
- WIDTH, 4, operand width in bits (signed two's complement); legal range 2..16.
- CW, $clog2(WIDTH), width of the internal step counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands a,b present
- in_ready  output  1  controller can accept operands (high only in IDLE)
- a  input  WIDTH  signed multiplicand
- b  input  WIDTH  signed multiplier
- out_valid  output  1  product y valid
- out_ready  input  1  consumer accepts y
- y  output  2*WIDTH  signed product a*b
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: clk and one reset only; rst is asynchronous and active-high. On rst: state=IDLE, out_valid=0, y=0, busy=0, counter=0, internal accumulator and registers=0. in_ready=1 once reset is applied.
- in_ready = (state==IDLE), decoded from the state register with no combinational path from inputs. busy = (state!=IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge where in_valid&&in_ready. On that edge:
  - M <= a, sign-extended to WIDTH+1 bits.
  - Q <= b.
  - A <= 0 (WIDTH+1 bits).
  - q_1 <= 0.
  - cnt <= 0.
- RUN: every edge performs one Booth step, then the shift:
  - {Q[0],q_1}=10: A <= A-M.
  - {Q[0],q_1}=01: A <= A+M.
  - 00/11: A unchanged.
  - Then {A,Q,q_1} is arithmetic-shifted right by 1, with the sign of A (MSB) replicated.
  - cnt increments.
- The WIDTH+1-bit A guarantees no overflow for any operand pair, including a=b=-2^(WIDTH-1).
- RUN -> DONE on the edge completing the step with cnt==WIDTH-1. On that edge y <= {A[WIDTH-1:0],Q} (post-shift value) and out_valid <= 1.
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge. Throughput is one product per WIDTH+2 cycles minimum (accept, WIDTH steps, one DONE cycle).
- DONE: y and out_valid are held stable indefinitely until out_ready=1. On the edge where out_valid&&out_ready, out_valid <= 0 and state <= IDLE. y retains its last value (y is not cleared). in_ready is high the following cycle.
- There is no same-cycle accept in DONE; a new operand is never accepted while out_valid=1.
- in_valid asserted in RUN or DONE is ignored, with no state change. a/b may change freely after the accept edge; the operands are captured.
- out_ready in IDLE or RUN has no effect.
- Reset mid-RUN or mid-DONE aborts immediately (asynchronously): the product is discarded and out_valid drops to 0 without a handshake.
- Result: y equals the exact signed product a*b for all 2^(2*WIDTH) operand pairs. y range is [-(2^(2W-2)-2^(W-1)), 2^(2W-2)].
- Illegal/unused FSM encoding returns to IDLE on the next edge with out_valid=0.

Test Plan (WIDTH=4):
- Basic: a=3, b=-2 accepted at edge T -> out_valid high after edge T+4, y=8'hFA (-6). busy=1 from T to handshake, in_ready=0 throughout.
- Corner: a=-8, b=-8 -> y=8'h40 (+64). a=-8, b=7 -> y=8'hC8 (-56). a=7, b=7 -> y=8'h31 (49). a=0, b=-8 -> y=8'h00.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y and out_valid stay constant. Raise out_ready -> out_valid=0 next cycle and in_ready=1.
- Ignore while busy: pulse in_valid with a=5, b=5 during RUN of a=2, b=3 -> y=8'h06, and no second result appears.
- Reset mid-operation: assert rst two cycles into RUN, then release -> out_valid=0, y=0, in_ready=1. A fresh a=-1, b=-1 yields y=8'h01 after 4 steps.
- Exhaustive: all 256 (a,b) pairs back-to-back with random out_ready delays -> every y matches the signed reference product, and accept-to-out_valid latency is always 4 edges.
